// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready pipeline that packs a signed immediate into RV32 I/S/B/J fields.
module imm_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr_in,
  input  logic [31:0] imm_in,
  input  logic [1:0]  ImmSrc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr_out,
  output logic        range_err,
  output logic        align_err,
  output logic [7:0]  err_count
);
  logic        s1_valid;
  logic [31:0] s1_instr;
  logic [20:0] s1_imm;
  logic [1:0]  s1_src;
  logic        s1_rerr, s1_aerr;
  logic        fit_is, fit_b, fit_j, rerr, aerr, adv;
  logic [31:0] pk;
  // an immediate fits when every bit above the field's sign position matches it
  assign fit_is = &imm_in[31:11] | ~|imm_in[31:11];
  assign fit_b  = &imm_in[31:12] | ~|imm_in[31:12];
  assign fit_j  = &imm_in[31:20] | ~|imm_in[31:20];
  assign rerr   = ImmSrc == 2'b11 ? !fit_j : ImmSrc == 2'b10 ? !fit_b : !fit_is;
  assign aerr   = ImmSrc[1] & imm_in[0];
  assign adv      = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv;
  assign pk = s1_src == 2'b00 ? {s1_imm[11:0], s1_instr[19:0]} :
              s1_src == 2'b01 ? {s1_imm[11:5], s1_instr[24:12], s1_imm[4:0], s1_instr[6:0]} :
              s1_src == 2'b10 ? {s1_imm[12], s1_imm[10:5], s1_instr[24:12], s1_imm[4:1], s1_imm[11], s1_instr[6:0]} :
                                {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_instr[11:0]};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_instr  <= '0;
      s1_imm    <= '0;
      s1_src    <= '0;
      s1_rerr   <= 1'b0;
      s1_aerr   <= 1'b0;
      out_valid <= 1'b0;
      instr_out <= '0;
      range_err <= 1'b0;
      align_err <= 1'b0;
      err_count <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_instr <= instr_in;
        s1_imm   <= imm_in[20:0];
        s1_src   <= ImmSrc;
        s1_rerr  <= rerr;
        s1_aerr  <= aerr;
      end
      if (adv) out_valid <= s1_valid;
      if (adv && s1_valid) begin
        instr_out <= pk;
        range_err <= s1_rerr;
        align_err <= s1_aerr;
      end
      if (out_valid && out_ready && (range_err || align_err) && err_count != 8'hff)
        err_count <= err_count + 8'd1;
    end
endmodule

// File: doc/imm_encoder.md
# imm_encoder

Pipelined immediate packer: takes a template instruction, a signed 32-bit immediate and an immediate format, and writes the immediate into the correct RISC-V instruction bit fields. It is the inverse of the datapath immediate extender and sits in the boot/debug loader path, where it patches branch, jump and load/store offsets before the instructions are written to instruction memory. The block has a two-stage valid/ready pipeline, range and alignment checking, and a saturating error counter.

## Interface
- No parameters. All widths are fixed by the RV32 encoding.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: the request on the `in_*` ports is valid.
- `in_ready` output 1: the block accepts the request this cycle.
- `instr_in` input 32: template instruction; all non-immediate bits pass through unchanged.
- `imm_in` input 32: signed immediate, in bytes for B and J formats.
- `ImmSrc` input 2: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `out_valid` output 1: the result is valid.
- `out_ready` input 1: the consumer accepts the result.
- `instr_out` output 32: the patched instruction.
- `range_err` output 1: the immediate does not fit the format. Qualified by `out_valid`.
- `align_err` output 1: B or J immediate with bit 0 set. Qualified by `out_valid`.
- `err_count` output 8: saturating count of results delivered with any error.

## Operation
- **Stage 1** registers `instr_in`, `imm_in`, `ImmSrc` and computes both error flags.
- **Stage 2** registers the packed instruction and the error flags.
- **Packing.** Bits not listed below come from the template.
  - I: [31:20] = imm[11:0].
  - S: [31:25] = imm[11:5]; [11:7] = imm[4:0].
  - B: [31] = imm[12]; [30:25] = imm[10:5]; [11:8] = imm[4:1]; [7] = imm[11].
  - J: [31] = imm[20]; [30:21] = imm[10:1]; [20] = imm[11]; [19:12] = imm[19:12].
- **Range rule.** `range_err` = 1 unless the upper bits all equal the sign bit:
  - I and S: imm[31:11] all equal.
  - B: imm[31:12] all equal.
  - J: imm[31:20] all equal.
- **Alignment rule.** `align_err` = imm[0] for B and J; always 0 for I and S.
- **On error** the instruction is still emitted. The truncated low bits are packed as normal, and the imm[0] of a misaligned immediate is dropped. No request is ever discarded.
- **Round-trip property.** With both errors 0, sign-extending `instr_out` in format `ImmSrc` reproduces `imm_in` exactly.
- **Error counter.** `err_count` increments by 1 on each output handshake (`out_valid && out_ready`) where `range_err || align_err`. It holds at 255.

## Timing
- **Reset** (asynchronous, `reset_n` = 0):
  - both stage valids = 0, so `out_valid` = 0;
  - `instr_out` = 0, `range_err` = 0, `align_err` = 0, `err_count` = 0;
  - `in_ready` = 1 while in reset and after reset.
- **Reset mid-operation** drops any in-flight requests. No output handshake occurs for them.
- **Latency.** An input handshake in cycle N produces `out_valid` = 1 in cycle N+2 when there is no backpressure.
- **Throughput.** One request per cycle, sustained.
- **Stage advance.** Stage 2 loads when `!out_valid || out_ready`. Stage 1 advances into stage 2 under the same condition.
- **`in_ready`** = `!s1_valid || (!out_valid || out_ready)`. This is combinational from `out_ready`; there is no combinational path from `in_valid` to `in_ready`.
- **Stall.** While `out_valid && !out_ready`, `instr_out`, `range_err` and `align_err` hold stable. At most 2 requests are buffered.
- **Simultaneous events.** An output handshake and an input handshake in the same cycle are both honoured, and the pipeline shifts.
- **Counter timing.** `err_count` updates on the clock edge that completes the erroring output handshake.

## Test plan
- **I format.** `instr_in` = 0x00000093, `imm_in` = 5, `ImmSrc` = 00 -> `instr_out` = 0x00500093 two cycles later, both errors 0.
- **S and B formats.**
  - S: template 0x0020A023, imm 8 -> 0x0020A423.
  - B: template 0x00000063, imm 0xFFFFFFFC -> 0xFE000EE3.
  - Both results have no errors.
- **J format.** Template 0x000000EF, imm 0x00000800 -> 0x001000EF. Then imm 0x00100000 -> `range_err` = 1 and `err_count` goes 0 -> 1.
- **Errors.**
  - I with imm 2048 -> 0x80000093 with `range_err` = 1.
  - B with imm 3 -> `align_err` = 1, and the instruction encodes offset 2.
  - 300 erroring results -> `err_count` = 255.
- **Backpressure.** Stream 4 back-to-back requests with `out_ready` held low for 5 cycles. Required response:
  - `in_ready` falls after the 2nd accept;
  - `instr_out` stays stable during the stall;
  - all 4 results emerge in order with none lost or duplicated.
- **Reset mid-stream.** Assert `reset_n` = 0 with 2 requests in flight -> `out_valid` = 0 and `err_count` = 0 immediately. After release, a new request completes with 2-cycle latency.
